// File: rtl/card_pkg.sv
// card_pkg
//   Shared definitions for the card dealer: FSM state type, shoe geometry
//   constants and the rank-to-blackjack-value mapping.
package card_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        DELIVER,
        SHUFFLE
    } state_t;

    localparam int NUM_RANKS      = 13;
    localparam int CARDS_PER_DECK = 52;
    localparam int CARD_W         = 5;

    // Rank 0 is the ace (value 1), ranks 1..8 are the pip cards 2..9,
    // ranks 9..12 are ten and the face cards, all worth 10.
    function automatic logic [CARD_W-1:0] rank_to_value(input logic [3:0] rank);
        logic [CARD_W-1:0] value;
        if (rank == 4'd0)
            value = 5'd1;
        else if (rank <= 4'd8)
            value = {1'b0, rank} + 5'd1;
        else
            value = 5'd10;
        return value;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// card_lfsr
//   16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11) used as the random source
//   for card selection. Steps on every clock edge.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset, loads SEED
//   lfsr     out  current 16-bit LFSR state
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    // Right-shifting Galois form: the bit falling out of position 0 is
    // folded back into the tap positions via the 0xB400 mask.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            lfsr <= SEED;
        else if (lfsr[0])
            lfsr <= (lfsr >> 1) ^ 16'hB400;
        else
            lfsr <= lfsr >> 1;
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer
//   Card source for the blackjack game FSM. Holds a shoe of DECKS x 52 cards
//   as per-rank counts, draws without replacement on request, and presents
//   player/dealer card values (1..10) on registered outputs.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   p_req      in   one-cycle pulse, draw a card for the player
//   d_req      in   one-cycle pulse, draw a card for the dealer
//   shuffle    in   one-cycle pulse, refill the shoe
//   pcard      out  last player card value (held)
//   dcard      out  last dealer card value (held)
//   pvalid     out  one-cycle pulse when pcard updates
//   dvalid     out  one-cycle pulse when dcard updates
//   busy       out  high whenever the FSM is not idle
//   remaining  out  cards left in the shoe
//   empty_err  out  one-cycle pulse when a request hits an empty shoe
// Configuration:
//   AUTO_RESHUFFLE_EN  when defined, a delivery that empties the shoe is
//                      followed automatically by a shuffle; empty_err is 0.
module card_dealer
    import card_pkg::*;
#(
    parameter int          DECKS     = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p_req,
    input  logic              d_req,
    input  logic              shuffle,
    output logic [CARD_W-1:0] pcard,
    output logic [CARD_W-1:0] dcard,
    output logic              pvalid,
    output logic              dvalid,
    output logic              busy,
    output logic [6:0]        remaining,
    output logic              empty_err
);

    localparam logic [3:0] FULL_COUNT = 4'(4 * DECKS);
    localparam logic [6:0] FULL_SHOE  = 7'(CARDS_PER_DECK * DECKS);
    localparam logic [3:0] LAST_RANK  = 4'(NUM_RANKS - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  rank;
    logic        target_p;
    logic        pend_p;
    logic        pend_d;
    logic        pend_s;
    logic [3:0]  counts [NUM_RANKS];
    logic [15:0] lfsr;
    logic        hit;
    logic        empty_hit;
    logic        start_draw;
    logic        clr_p;
    logic        clr_d;
    logic        clr_s;

    card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    // Next-state and request bookkeeping. A pending shuffle always wins in
    // IDLE; an empty shoe turns a pending request into an error pulse and
    // drops it, player first when both are waiting.
    always_comb begin
        next_state = state;
        hit        = (counts[rank] != 4'd0);
        start_draw = 1'b0;
        empty_hit  = 1'b0;
        clr_p      = 1'b0;
        clr_d      = 1'b0;
        clr_s      = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (pend_s) begin
                    clr_s      = 1'b1;
                    next_state = SHUFFLE;
                end else if (pend_p || pend_d) begin
                    if (remaining != 7'd0) begin
                        start_draw = 1'b1;
                        next_state = PICK;
                    end else begin
                        empty_hit = 1'b1;
                        clr_p     = pend_p;
                        clr_d     = !pend_p;
                    end
                end
            end
            PICK: begin
                if (hit) begin
                    clr_p      = target_p;
                    clr_d      = !target_p;
                    next_state = DELIVER;
                end
            end
            DELIVER: begin
`ifdef AUTO_RESHUFFLE_EN
                if (remaining == 7'd0)
                    next_state = SHUFFLE;
                else
                    next_state = IDLE;
`else
                next_state = IDLE;
`endif
            end
            SHUFFLE: begin
                if (rank == LAST_RANK)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Datapath: pending flags, the shoe counts, the probing rank pointer
    // (also reused as the reload index while shuffling) and card outputs.
    // A new request pulse wins over a clear landing in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_p    <= 1'b0;
            pend_d    <= 1'b0;
            pend_s    <= 1'b0;
            rank      <= 4'd0;
            target_p  <= 1'b0;
            remaining <= FULL_SHOE;
            pcard     <= '0;
            dcard     <= '0;
            pvalid    <= 1'b0;
            dvalid    <= 1'b0;
            empty_err <= 1'b0;
            for (int i = 0; i < NUM_RANKS; i++)
                counts[i] <= FULL_COUNT;
        end else begin
            pend_p <= p_req   | (pend_p & ~clr_p);
            pend_d <= d_req   | (pend_d & ~clr_d);
            pend_s <= shuffle | (pend_s & ~clr_s);
            pvalid <= 1'b0;
            dvalid <= 1'b0;
`ifdef AUTO_RESHUFFLE_EN
            empty_err <= 1'b0;
`else
            empty_err <= empty_hit;
`endif

            case (state)
                IDLE: begin
                    if (clr_s) begin
                        rank <= 4'd0;
                    end else if (start_draw) begin
                        rank     <= 4'(lfsr % 16'd13);
                        target_p <= pend_p;
                    end
                end
                PICK: begin
                    if (hit) begin
                        counts[rank] <= counts[rank] - 4'd1;
                        remaining    <= remaining - 7'd1;
                        if (target_p) begin
                            pcard  <= rank_to_value(rank);
                            pvalid <= 1'b1;
                        end else begin
                            dcard  <= rank_to_value(rank);
                            dvalid <= 1'b1;
                        end
                    end else begin
                        rank <= (rank == LAST_RANK) ? 4'd0 : rank + 4'd1;
                    end
                end
                DELIVER: begin
                    rank <= 4'd0;
                end
                SHUFFLE: begin
                    counts[rank] <= FULL_COUNT;
                    rank         <= rank + 4'd1;
                    if (rank == LAST_RANK)
                        remaining <= FULL_SHOE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer
//   Randomised bench for card_dealer (DECKS=1). The reference model tracks
//   the shoe as a multiset of card values: every delivered value must still
//   be present in the model, and the model's card total must match the
//   remaining output. Also checks latency bounds, the empty-shoe behaviour,
//   simultaneous requests and reset in the middle of a draw.
module tb_card_dealer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       p_req;
    logic       d_req;
    logic       shuffle;
    logic [4:0] pcard;
    logic [4:0] dcard;
    logic       pvalid;
    logic       dvalid;
    logic       busy;
    logic [6:0] remaining;
    logic       empty_err;

    int checks = 0;
    int errors = 0;
    int model_cnt [11];
    int model_rem;
    int hist [11];
    int sum_vals;
    int empty_count = 0;
    int last_p;
    int last_d;

    card_dealer #(.DECKS(1), .LFSR_SEED(16'hACE1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .p_req     (p_req),
        .d_req     (d_req),
        .shuffle   (shuffle),
        .pcard     (pcard),
        .dcard     (dcard),
        .pvalid    (pvalid),
        .dvalid    (dvalid),
        .busy      (busy),
        .remaining (remaining),
        .empty_err (empty_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (empty_err)
            empty_count++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelFill();
        for (int v = 1; v <= 9; v++)
            model_cnt[v] = 4;
        model_cnt[10] = 16;
        model_rem = 52;
    endtask

    // Drive one cycle of request pulses; called on a falling edge, returns on
    // the falling edge after the sampling edge.
    task automatic applyStimulus(input bit pl, input bit dl, input bit sh);
        p_req   = pl;
        d_req   = dl;
        shuffle = sh;
        @(negedge clock);
        p_req   = 1'b0;
        d_req   = 1'b0;
        shuffle = 1'b0;
    endtask

    // Remove a delivered value from the model shoe, complaining if the shoe
    // could not have contained it.
    task automatic noteDelivery(input bit player, input int v);
        bit legal;
        legal = (v >= 1 && v <= 10);
        if (legal)
            legal = (model_cnt[v] > 0);
        checkOutput(player ? "pcard_legal" : "dcard_legal", int'(legal), 1);
        if (legal) begin
            model_cnt[v]--;
            hist[v]++;
        end
        model_rem--;
        sum_vals += v;
        if (player)
            last_p = v;
        else
            last_d = v;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (busy)
            checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic drawCard(input bit player);
        int lat;
        int v;
        int other_before;
        other_before = player ? last_d : last_p;
        applyStimulus(player, !player, 1'b0);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (player ? pvalid : dvalid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checkOutput(player ? "pvalid_timeout" : "dvalid_timeout", 0, 1);
            return;
        end
        checkOutput("latency_in_range", int'(lat >= 2 && lat <= 14), 1);
        checkOutput("other_valid_low", int'(player ? dvalid : pvalid), 0);
        v = player ? int'(pcard) : int'(dcard);
        noteDelivery(player, v);
        checkOutput("remaining", int'(remaining), model_rem);
        checkOutput("other_card_held", player ? int'(dcard) : int'(pcard), other_before);
        @(negedge clock);
        checkOutput("valid_one_cycle", int'(player ? pvalid : dvalid), 0);
        waitIdle();
    endtask

    initial begin
        int pv_at;
        int dv_at;
        int pv_n;
        int dv_n;
        int start_rem;
        int only_v;
        int e_n;

        reset_n = 1'b0;
        p_req   = 1'b0;
        d_req   = 1'b0;
        shuffle = 1'b0;
        last_p  = 0;
        last_d  = 0;
        sum_vals = 0;
        for (int v = 0; v <= 10; v++)
            hist[v] = 0;
        repeat (3) @(negedge clock);

        checkOutput("reset_pcard", int'(pcard), 0);
        checkOutput("reset_dcard", int'(dcard), 0);
        checkOutput("reset_pvalid", int'(pvalid), 0);
        checkOutput("reset_dvalid", int'(dvalid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_empty_err", int'(empty_err), 0);
        checkOutput("reset_remaining", int'(remaining), 52);
        reset_n = 1'b1;
        @(negedge clock);

        // Empty the whole shoe with randomly targeted draws.
        modelFill();
        for (int i = 0; i < 52; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            drawCard(1'($urandom_range(0, 1)));
        end
        for (int v = 1; v <= 9; v++)
            checkOutput($sformatf("hist_%0d", v), hist[v], 4);
        checkOutput("hist_10", hist[10], 16);
        checkOutput("sum_values", sum_vals, 340);

`ifdef AUTO_RESHUFFLE_EN
        checkOutput("auto_reshuffle_remaining", int'(remaining), 52);
        modelFill();
        drawCard(1'b1);
`else
        checkOutput("drained_remaining", int'(remaining), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        e_n  = 0;
        pv_n = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (empty_err)
                e_n++;
            if (pvalid)
                pv_n++;
        end
        checkOutput("empty_err_pulses", e_n, 1);
        checkOutput("empty_no_pvalid", pv_n, 0);
        checkOutput("empty_pcard_held", int'(pcard), last_p);
        checkOutput("empty_remaining", int'(remaining), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        waitIdle();
        checkOutput("shuffle_remaining", int'(remaining), 52);
        modelFill();
`endif

        // Player and dealer requested in the same cycle.
        start_rem = model_rem;
        applyStimulus(1'b1, 1'b1, 1'b0);
        pv_at = 0;
        dv_at = 0;
        pv_n  = 0;
        dv_n  = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (pvalid) begin
                pv_n++;
                if (pv_at == 0)
                    pv_at = n;
                noteDelivery(1'b1, int'(pcard));
            end
            if (dvalid) begin
                dv_n++;
                if (dv_at == 0)
                    dv_at = n;
                noteDelivery(1'b0, int'(dcard));
            end
        end
        checkOutput("both_pvalid_count", pv_n, 1);
        checkOutput("both_dvalid_count", dv_n, 1);
        checkOutput("both_player_first", int'(pv_at > 0 && dv_at > pv_at), 1);
        checkOutput("both_remaining", int'(remaining), start_rem - 2);
        waitIdle();

        // Draw down to a single card, then the last draw must return it.
        while (model_rem > 1) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            drawCard(1'($urandom_range(0, 1)));
        end
        only_v = 0;
        for (int v = 1; v <= 10; v++)
            if (model_cnt[v] > 0)
                only_v = v;
        drawCard(1'b1);
        checkOutput("last_card_value", int'(pcard), only_v);

        // Reset while a draw is in PICK.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("midpick_busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midpick_reset_pcard", int'(pcard), 0);
        checkOutput("midpick_reset_dcard", int'(dcard), 0);
        checkOutput("midpick_reset_pvalid", int'(pvalid), 0);
        checkOutput("midpick_reset_busy", int'(busy), 0);
        checkOutput("midpick_reset_remaining", int'(remaining), 52);
        @(negedge clock);
        reset_n = 1'b1;
        pv_n = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (pvalid || dvalid)
                pv_n++;
        end
        checkOutput("no_valid_after_reset", pv_n, 0);

`ifdef AUTO_RESHUFFLE_EN
        checkOutput("empty_err_never", empty_count, 0);
`else
        checkOutput("empty_err_total", empty_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
